// File: rtl/read_to_sdram.sv
// read_to_sdram: drains 16-bit words from an FX2 slave FIFO, pairs them into
// 32-bit words (first half -> [15:0], second half -> [31:16]) and writes each
// pair to SDRAM over a pipelined Wishbone master port at a wrapping address.
//
// Ports
//   CLKOUT            sole clock (rising edge)
//   rst_n             synchronous reset, active-HIGH despite the name
//   FLAGA             FIFO data-available flag
//   FDATA             FIFO data bus, only ever read (left high-Z here)
//   SLRD/SLOE         FIFO read strobe / output enable, active-low
//   SLWR, FIFOADR     held inactive / endpoint 0
//   IFCLK             copy of CLKOUT
//   LED               low nibble of the completed-word counter
//   cstate            current FSM state code
//   read_ack          one-cycle pulse per completed SDRAM write
//   data_o            slave read data, unused (write-only master)
//   stall_o           slave stall; strobe simply stays up while stalled
//   sdram_ack         slave ack, honoured only while a request is open
//   cyc_i/stb_i/we_i  Wishbone cycle, strobe, write enable
//   sel_i             byte select, all lanes
//   addr_i, data_i    word address and write data
module read_to_sdram #(
    parameter int WORDS = 120
) (
    input  logic        CLKOUT,
    input  logic        rst_n,
    input  logic        FLAGA,
    inout  wire  [15:0] FDATA,
    output logic        SLRD,
    output logic        SLOE,
    output logic        SLWR,
    output logic        IFCLK,
    output logic [1:0]  FIFOADR,
    output logic [3:0]  LED,
    output logic [2:0]  cstate,
    output logic        read_ack,
    input  logic [31:0] data_o,
    input  logic        stall_o,
    input  logic        sdram_ack,
    output logic        stb_i,
    output logic        cyc_i,
    output logic        we_i,
    output logic [3:0]  sel_i,
    output logic [31:0] addr_i,
    output logic [31:0] data_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OE     = 3'd1,
        RD_LO  = 3'd2,
        RD_HI  = 3'd3,
        WB_REQ = 3'd4,
        WB_END = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] cnt_q, cnt_d;

    // The strobe is held through stalls by the FSM staying in WB_REQ, so the
    // stall input carries no extra logic; read data is never consumed.
    logic unused_inputs;
    assign unused_inputs = ^{data_o, stall_o};

    // Fixed FIFO-side and bus-side constants, independent of reset.
    assign SLWR    = 1'b1;
    assign FIFOADR = 2'b00;
    assign sel_i   = 4'b1111;
    assign IFCLK   = CLKOUT;

    // State register
    always_ff @(posedge CLKOUT) begin
        if (rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath. FDATA is captured on the same edge that sees
    // SLRD low, which is also the edge on which the FIFO advances.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   if (FLAGA) state_d = OE;
            OE:     state_d = RD_LO;
            RD_LO: begin
                if (FLAGA) begin
                    data_d[15:0] = FDATA;
                    state_d      = RD_HI;
                end
            end
            RD_HI: begin
                if (FLAGA) begin
                    data_d[31:16] = FDATA;
                    state_d       = WB_REQ;
                end
            end
            WB_REQ: if (sdram_ack) state_d = WB_END;
            WB_END: begin
                addr_d  = (addr_q == 32'(WORDS - 1)) ? '0 : addr_q + 32'd1;
                cnt_d   = cnt_q + 32'd1;
                state_d = FLAGA ? RD_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        SLOE     = (state_q == IDLE);
        SLRD     = !(((state_q == RD_LO) || (state_q == RD_HI)) && FLAGA);
        cyc_i    = (state_q == WB_REQ);
        stb_i    = (state_q == WB_REQ);
        we_i     = (state_q == WB_REQ);
        read_ack = (state_q == WB_END);
        cstate   = state_q;
        addr_i   = addr_q;
        data_i   = data_q;
        LED      = cnt_q[3:0];
    end

endmodule

// File: tb/tb_read_to_sdram.sv
module tb_read_to_sdram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    wire         FLAGA;
    wire  [15:0] FDATA;
    logic        SLRD, SLOE, SLWR, IFCLK;
    logic [1:0]  FIFOADR;
    logic [3:0]  LED;
    logic [2:0]  cstate;
    logic        read_ack;
    logic [31:0] data_o = 32'h0;
    logic        stall_o = 1'b0;
    wire         sdram_ack;
    logic        stb_i, cyc_i, we_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i, data_i;

    // FIFO model: presents fifo_base + fifo_rd, advances on edges with SLRD low
    logic [15:0] fifo_base = 16'd0;
    logic [15:0] fifo_len  = 16'd0;
    logic [15:0] fifo_rd   = 16'd0;
    logic        fifo_clr  = 1'b1;
    logic        flag_en   = 1'b0;
    logic        flag_hold = 1'b0;
    assign FDATA = fifo_base + fifo_rd;
    assign FLAGA = flag_en && !flag_hold && (fifo_rd < fifo_len);

    // Slave model: acks after ack_delay non-stalled strobe cycles
    logic ack_q = 1'b0;
    logic ack_force = 1'b0;
    logic ack_en = 1'b1;
    int   ack_delay = 1;
    int   wait_cnt = 0;
    assign sdram_ack = ack_q | ack_force;

    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int wr_n = 0;
    int rack_n = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    read_to_sdram #(.WORDS(120)) dut (
        .CLKOUT(clk), .rst_n(rst_n), .FLAGA(FLAGA), .FDATA(FDATA),
        .SLRD(SLRD), .SLOE(SLOE), .SLWR(SLWR), .IFCLK(IFCLK),
        .FIFOADR(FIFOADR), .LED(LED), .cstate(cstate), .read_ack(read_ack),
        .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack),
        .stb_i(stb_i), .cyc_i(cyc_i), .we_i(we_i), .sel_i(sel_i),
        .addr_i(addr_i), .data_i(data_i)
    );

    always @(posedge clk) begin
        if (fifo_clr) fifo_rd <= 16'd0;
        else if (SLRD === 1'b0) fifo_rd <= fifo_rd + 16'd1;
    end

    always @(posedge clk) begin
        if (fifo_clr) begin
            ack_q <= 1'b0;
            wait_cnt <= 0;
        end else if (ack_en && cyc_i && stb_i && !stall_o && !ack_q) begin
            if (wait_cnt >= ack_delay - 1) begin
                ack_q <= 1'b1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            ack_q <= 1'b0;
            if (!(cyc_i && stb_i)) wait_cnt <= 0;
        end
    end

    // Bus monitor: records each accepted write and each read_ack pulse
    always @(posedge clk) begin
        if (fifo_clr) begin
            wr_n <= 0;
            rack_n <= 0;
        end else begin
            if (cyc_i && stb_i && we_i && sdram_ack) begin
                wr_addr[wr_n[7:0]] <= addr_i;
                wr_data[wr_n[7:0]] <= data_i;
                wr_n <= wr_n + 1;
            end
            if (read_ack) rack_n <= rack_n + 1;
        end
    end

    // Per-cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        checks++;
        if (SLWR !== 1'b1 || FIFOADR !== 2'b00 || sel_i !== 4'hF || IFCLK !== 1'b0) begin
            failures++;
            $display("FAIL const_outputs: SLWR=%b FIFOADR=%b sel_i=%h IFCLK=%b", SLWR, FIFOADR, sel_i, IFCLK);
        end
        checks++;
        if (FLAGA === 1'b0 && SLRD !== 1'b1) begin
            failures++;
            $display("FAIL slrd_without_flag: SLRD=%b while FLAGA=0", SLRD);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        fifo_clr = 1'b1;
        flag_en = 1'b0;
        flag_hold = 1'b0;
        stall_o = 1'b0;
        ack_force = 1'b0;
        ack_en = 1'b1;
        ack_delay = 1;
        tick();
        tick();
        rst_n = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim);
        for (int i = 0; i < lim && cstate !== s; i++) tick();
    endtask

    task automatic wait_writes(input int n, input int lim);
        for (int i = 0; i < lim && wr_n < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        fifo_clr = 1'b1;
        tick();
        tick();
        checks++;
        if (cstate !== 3'd0 || cyc_i !== 1'b0 || stb_i !== 1'b0 || we_i !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: cstate=%0d cyc=%b stb=%b we=%b, want 0 0 0 0", cstate, cyc_i, stb_i, we_i);
        end
        checks++;
        if (addr_i !== 32'h0 || data_i !== 32'h0 || LED !== 4'h0 || read_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: addr=%h data=%h LED=%h ack=%b, want all 0", addr_i, data_i, LED, read_ack);
        end
        checks++;
        if (SLRD !== 1'b1 || SLOE !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo: SLRD=%b SLOE=%b, want 1 1", SLRD, SLOE);
        end
    endtask

    task automatic test_two_words();
        do_reset();
        fifo_base = 16'd0;
        fifo_len = 16'd4;
        ack_delay = 4;
        flag_en = 1'b1;
        wait_writes(2, 80);
        repeat (3) tick();
        checks++;
        if (wr_n !== 2) begin
            failures++;
            $display("FAIL two_words_count: writes=%0d want 2", wr_n);
        end
        checks++;
        if (wr_addr[0] !== 32'd0 || wr_data[0] !== 32'h00010000) begin
            failures++;
            $display("FAIL two_words_w0: addr=%h data=%h want 0 00010000", wr_addr[0], wr_data[0]);
        end
        checks++;
        if (wr_addr[1] !== 32'd1 || wr_data[1] !== 32'h00030002) begin
            failures++;
            $display("FAIL two_words_w1: addr=%h data=%h want 1 00030002", wr_addr[1], wr_data[1]);
        end
        checks++;
        if (rack_n !== 2 || LED !== 4'd2 || addr_i !== 32'd2 || cstate !== 3'd0) begin
            failures++;
            $display("FAIL two_words_end: acks=%0d LED=%0d addr=%0d cstate=%0d want 2 2 2 0", rack_n, LED, addr_i, cstate);
        end
    endtask

    task automatic test_flag_drop();
        do_reset();
        fifo_base = 16'd100;
        fifo_len = 16'd2;
        flag_en = 1'b1;
        wait_state(3'd3, 10);
        flag_hold = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (cstate !== 3'd3 || SLRD !== 1'b1 || cyc_i !== 1'b0 || data_i[15:0] !== 16'd100) begin
                failures++;
                $display("FAIL flag_drop_hold: cstate=%0d SLRD=%b cyc=%b lo=%0d want 3 1 0 100", cstate, SLRD, cyc_i, data_i[15:0]);
            end
        end
        flag_hold = 1'b0;
        wait_writes(1, 20);
        checks++;
        if (wr_n !== 1 || wr_data[0] !== 32'h00650064 || wr_addr[0] !== 32'd0) begin
            failures++;
            $display("FAIL flag_drop_resume: writes=%0d data=%h addr=%h want 1 00650064 0", wr_n, wr_data[0], wr_addr[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        fifo_base = 16'd0;
        fifo_len = 16'd242;
        flag_en = 1'b1;
        wait_writes(121, 2000);
        repeat (3) tick();
        checks++;
        if (wr_n !== 121 || wr_addr[119] !== 32'd119 || wr_addr[120] !== 32'd0) begin
            failures++;
            $display("FAIL wrap_addr: writes=%0d a119=%0d a120=%0d want 121 119 0", wr_n, wr_addr[119], wr_addr[120]);
        end
        checks++;
        if (wr_data[120] !== 32'h00F100F0 || wr_data[0] !== 32'h00010000) begin
            failures++;
            $display("FAIL wrap_data: d120=%h d0=%h want 00f100f0 00010000", wr_data[120], wr_data[0]);
        end
        checks++;
        if (rack_n !== 121 || LED !== 4'd9 || addr_i !== 32'd1) begin
            failures++;
            $display("FAIL wrap_count: acks=%0d LED=%0d addr=%0d want 121 9 1", rack_n, LED, addr_i);
        end
    endtask

    task automatic test_stall();
        do_reset();
        fifo_base = 16'd200;
        fifo_len = 16'd2;
        stall_o = 1'b1;
        flag_en = 1'b1;
        wait_state(3'd4, 10);
        repeat (5) begin
            tick();
            checks++;
            if (cstate !== 3'd4 || cyc_i !== 1'b1 || stb_i !== 1'b1 || we_i !== 1'b1 ||
                addr_i !== 32'd0 || data_i !== 32'h00C900C8) begin
                failures++;
                $display("FAIL stall_hold: cstate=%0d cyc=%b stb=%b we=%b addr=%h data=%h want 4 1 1 1 0 00c900c8",
                         cstate, cyc_i, stb_i, we_i, addr_i, data_i);
            end
        end
        stall_o = 1'b0;
        wait_writes(1, 10);
        repeat (2) tick();
        checks++;
        if (wr_n !== 1 || wr_data[0] !== 32'h00C900C8 || rack_n !== 1 || addr_i !== 32'd1 || cyc_i !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: writes=%0d data=%h acks=%0d addr=%0d cyc=%b want 1 00c900c8 1 1 0",
                     wr_n, wr_data[0], rack_n, addr_i, cyc_i);
        end
    endtask

    task automatic test_ack_outside();
        do_reset();
        ack_force = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (cstate !== 3'd0 || read_ack !== 1'b0 || cyc_i !== 1'b0 || LED !== 4'd0) begin
                failures++;
                $display("FAIL stray_ack: cstate=%0d read_ack=%b cyc=%b LED=%0d want 0 0 0 0", cstate, read_ack, cyc_i, LED);
            end
        end
        ack_force = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        fifo_base = 16'd300;
        fifo_len = 16'd2;
        ack_en = 1'b0;
        flag_en = 1'b1;
        wait_state(3'd4, 10);
        checks++;
        if (cyc_i !== 1'b1 || data_i !== 32'h012D012C) begin
            failures++;
            $display("FAIL reset_mid_pre: cyc=%b data=%h want 1 012d012c", cyc_i, data_i);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cyc_i !== 1'b0 || stb_i !== 1'b0 || cstate !== 3'd0 || addr_i !== 32'd0 || data_i !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: cyc=%b stb=%b cstate=%0d addr=%h data=%h want 0 0 0 0 0", cyc_i, stb_i, cstate, addr_i, data_i);
        end
        checks++;
        if (SLOE !== 1'b1 || SLRD !== 1'b1 || read_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fifo: SLOE=%b SLRD=%b read_ack=%b want 1 1 0", SLOE, SLRD, read_ack);
        end
        rst_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_flag_drop();
        test_wrap();
        test_stall();
        test_ack_outside();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
